traffic_light_ctrl: RTL and testbench



---
 rtl/traffic_light_ctrl.sv | 148 ++++++++++++++
 tb/tb_traffic_light_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_ctrl.sv
// Two-road intersection controller with pedestrian walk phase and flashing-yellow override.
//
// Sequence: MAIN_G -> MAIN_Y -> RED_A -> SIDE_G -> SIDE_Y -> RED_B -> (PED_WALK ->) MAIN_G.
// A latched pedestrian request inserts PED_WALK after RED_B. flash_en forces FLASH from
// any state; leaving FLASH goes through RED_B for clearance.
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    synchronous active-low reset
//   ped_req    pedestrian request (level or pulse)
//   flash_en   flashing-yellow override enable
//   main_light main-road head {R,Y,G}
//   side_light side-road head {R,Y,G}
//   walk       pedestrian walk lamp
//   state_o    current state encoding (debug)
module traffic_light_ctrl #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned GREEN_T  = 20,
  parameter int unsigned YELLOW_T = 4,
  parameter int unsigned ALLRED_T = 2,
  parameter int unsigned PED_T    = 10,
  parameter int unsigned FLASH_T  = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ped_req,
  input  logic       flash_en,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    StMainG   = 3'd0,
    StMainY   = 3'd1,
    StRedA    = 3'd2,
    StSideG   = 3'd3,
    StSideY   = 3'd4,
    StRedB    = 3'd5,
    StPedWalk = 3'd6,
    StFlash   = 3'd7
  } state_e;

  localparam logic [2:0] LightRed    = 3'b100;
  localparam logic [2:0] LightYellow = 3'b010;
  localparam logic [2:0] LightGreen  = 3'b001;
  localparam logic [2:0] LightDark   = 3'b000;

  // Counter reload values; a phase of duration D counts D-1 down to 0.
  localparam logic [CNT_W-1:0] GreenLd  = CNT_W'(GREEN_T - 1);
  localparam logic [CNT_W-1:0] YellowLd = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AllredLd = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] PedLd    = CNT_W'(PED_T - 1);
  localparam logic [CNT_W-1:0] FlashLd  = CNT_W'(FLASH_T - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ped_pending_q, ped_pending_d;
  logic             blink_q, blink_d;

  function automatic logic [CNT_W-1:0] load_val(input state_e s);
    logic [CNT_W-1:0] v;
    unique case (s)
      StMainG, StSideG: v = GreenLd;
      StMainY, StSideY: v = YellowLd;
      StRedA, StRedB:   v = AllredLd;
      StPedWalk:        v = PedLd;
      StFlash:          v = FlashLd;
      default:          v = AllredLd;
    endcase
    return v;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= StRedB;
      cnt_q         <= AllredLd;
      ped_pending_q <= 1'b0;
      blink_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ped_pending_q <= ped_pending_d;
      blink_q       <= blink_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q - 1'b1;
    blink_d       = blink_q;
    ped_pending_d = ped_pending_q | ped_req;

    if (state_q == StFlash) begin
      if (!flash_en) begin
        state_d = StRedB;
        cnt_d   = AllredLd;
        blink_d = 1'b0;
      end else if (cnt_q == '0) begin
        cnt_d   = FlashLd;
        blink_d = ~blink_q;
      end
    end else if (flash_en) begin
      // Override beats the phase timer; any pending walk stays latched.
      state_d = StFlash;
      cnt_d   = FlashLd;
      blink_d = 1'b1;
    end else if (cnt_q == '0) begin
      unique case (state_q)
        StMainG:   state_d = StMainY;
        StMainY:   state_d = StRedA;
        StRedA:    state_d = StSideG;
        StSideG:   state_d = StSideY;
        StSideY:   state_d = StRedB;
        StRedB:    state_d = ped_pending_q ? StPedWalk : StMainG;
        StPedWalk: state_d = StMainG;
        default:   state_d = StRedB;
      endcase
      cnt_d = load_val(state_d);
      // A request coinciding with walk entry is treated as served.
      if (state_d == StPedWalk) begin
        ped_pending_d = 1'b0;
      end
    end
  end

  always_comb begin
    main_light = LightRed;
    side_light = LightRed;
    walk       = 1'b0;
    unique case (state_q)
      StMainG:   main_light = LightGreen;
      StMainY:   main_light = LightYellow;
      StSideG:   side_light = LightGreen;
      StSideY:   side_light = LightYellow;
      StPedWalk: walk       = 1'b1;
      StFlash: begin
        main_light = blink_q ? LightYellow : LightDark;
        side_light = blink_q ? LightYellow : LightDark;
      end
      default: ;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Self-checking bench for traffic_light_ctrl: directed scenarios plus a randomized run,
// compared every cycle against a phase-level behavioural model.
module tb_traffic_light_ctrl;

  localparam int GREEN_T  = 5;
  localparam int YELLOW_T = 2;
  localparam int ALLRED_T = 1;
  localparam int PED_T    = 3;
  localparam int FLASH_T  = 2;

  localparam int S_MAIN_G = 0, S_MAIN_Y = 1, S_RED_A = 2, S_SIDE_G = 3;
  localparam int S_SIDE_Y = 4, S_RED_B = 5, S_PED = 6, S_FLASH = 7;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ped_req = 1'b0;
  logic       flash_en = 1'b0;
  logic [2:0] main_light, side_light, state_o;
  logic       walk;

  traffic_light_ctrl #(
    .CNT_W(8), .GREEN_T(GREEN_T), .YELLOW_T(YELLOW_T), .ALLRED_T(ALLRED_T),
    .PED_T(PED_T), .FLASH_T(FLASH_T)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ped_req(ped_req), .flash_en(flash_en),
    .main_light(main_light), .side_light(side_light), .walk(walk), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Phase-level model: current phase, cycles already spent in it, request latch, blink.
  int m_state = S_RED_B;
  int m_elapsed = 0;
  bit m_ped = 0;
  bit m_blink = 0;

  // Observation bookkeeping for duration and walk-count checks.
  int  prev_obs = S_RED_B;
  int  run_len = 0;
  bit  run_valid = 0;
  bit  dur_chk_en = 0;
  int  walk_entries = 0;

  function automatic int dur(input int s);
    case (s)
      S_MAIN_G, S_SIDE_G: return GREEN_T;
      S_MAIN_Y, S_SIDE_Y: return YELLOW_T;
      S_PED:              return PED_T;
      default:            return ALLRED_T;
    endcase
  endfunction

  function automatic int seq_next(input int s, input bit ped);
    case (s)
      S_RED_B: return ped ? S_PED : S_MAIN_G;
      S_PED:   return S_MAIN_G;
      default: return s + 1;
    endcase
  endfunction

  // Expected {main, side, walk} for the model's phase.
  function automatic logic [6:0] exp_out(input int s, input bit b);
    case (s)
      S_MAIN_G: return {3'b001, 3'b100, 1'b0};
      S_MAIN_Y: return {3'b010, 3'b100, 1'b0};
      S_SIDE_G: return {3'b100, 3'b001, 1'b0};
      S_SIDE_Y: return {3'b100, 3'b010, 1'b0};
      S_PED:    return {3'b100, 3'b100, 1'b1};
      S_FLASH:  return b ? {3'b010, 3'b010, 1'b0} : {3'b000, 3'b000, 1'b0};
      default:  return {3'b100, 3'b100, 1'b0};
    endcase
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit served = 0;
    if (!reset_n) begin
      m_state = S_RED_B; m_elapsed = 0; m_ped = 0; m_blink = 0;
      return;
    end
    if (m_state == S_FLASH) begin
      if (!flash_en) begin
        m_state = S_RED_B; m_elapsed = 0; m_blink = 0;
      end else begin
        m_elapsed++;
        if (m_elapsed == FLASH_T) begin
          m_blink = ~m_blink; m_elapsed = 0;
        end
      end
    end else if (flash_en) begin
      m_state = S_FLASH; m_elapsed = 0; m_blink = 1;
    end else begin
      m_elapsed++;
      if (m_elapsed == dur(m_state)) begin
        m_state = seq_next(m_state, m_ped);
        m_elapsed = 0;
        served = (m_state == S_PED);
      end
    end
    m_ped = served ? 1'b0 : (m_ped | ped_req);
  endtask

  task automatic tick();
    logic [6:0] e;
    int cur;
    @(posedge clk);
    model_step();
    #1;
    e = exp_out(m_state, m_blink);
    cur = int'(state_o);
    chk("state", cur, m_state);
    chk("main_light", int'(main_light), int'(e[6:4]));
    chk("side_light", int'(side_light), int'(e[3:1]));
    chk("walk", int'(walk), int'(e[0]));
    if (cur != S_FLASH)
      chk("safety", int'(main_light != 3'b100 && side_light != 3'b100), 0);
    if (cur == S_PED && prev_obs != S_PED) walk_entries++;
    if (cur != prev_obs) begin
      if (dur_chk_en && run_valid && prev_obs != S_FLASH && cur != S_FLASH)
        chk("phase_len", run_len, dur(prev_obs));
      run_valid = 1;
      run_len = 1;
    end else begin
      run_len++;
    end
    prev_obs = cur;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Advance until the model sits in phase s with the given elapsed count.
  task automatic wait_phase(input int s, input int el);
    bit found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (m_state == s && m_elapsed == el) found = 1;
      else tick();
    end
    chk("wait_phase", int'(found), 1);
  endtask

  initial begin
    // Reset
    run(3);
    chk("rst_state", int'(state_o), S_RED_B);
    chk("rst_main", int'(main_light), 3'b100);
    chk("rst_side", int'(side_light), 3'b100);
    chk("rst_walk", int'(walk), 0);

    // 1: free-running sequence, 16-cycle period
    reset_n = 1'b1;
    tick();
    chk("s1_first_main_g", int'(state_o), S_MAIN_G);
    run(31);

    // 2: single pulse during SIDE_G
    wait_phase(S_SIDE_G, 1);
    walk_entries = 0;
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    run(40);
    chk("s2_walk_count", walk_entries, 1);

    // 3: request held 20 cycles from start of MAIN_G
    wait_phase(S_MAIN_G, 0);
    walk_entries = 0;
    ped_req = 1'b1;
    run(20);
    ped_req = 1'b0;
    run(60);
    chk("s3_walk_count", walk_entries, 2);

    // 4: flash override mid MAIN_G
    wait_phase(S_MAIN_G, 2);
    flash_en = 1'b1;
    tick();
    chk("s4_flash_entry", int'(state_o), S_FLASH);
    chk("s4_flash_yellow", int'(main_light), 3'b010);
    run(8);
    flash_en = 1'b0;
    tick();
    chk("s4_red_b", int'(state_o), S_RED_B);
    run(8);

    // 5a: reset during SIDE_Y with a pending request
    wait_phase(S_MAIN_G, 1);
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    wait_phase(S_SIDE_Y, 0);
    reset_n = 1'b0;
    tick();
    chk("s5_rst_main", int'(main_light), 3'b100);
    chk("s5_rst_side", int'(side_light), 3'b100);
    reset_n = 1'b1;
    walk_entries = 0;
    run(20);
    chk("s5_no_walk", walk_entries, 0);

    // 5b: reset during FLASH, with flash still requested at the reset edge
    flash_en = 1'b1;
    ped_req = 1'b1;
    run(3);
    ped_req = 1'b0;
    reset_n = 1'b0;
    tick();
    chk("s5_rst_flash_state", int'(state_o), S_RED_B);
    flash_en = 1'b0;
    reset_n = 1'b1;
    walk_entries = 0;
    run(20);
    chk("s5b_no_walk", walk_entries, 0);

    // 6: random requests and override
    dur_chk_en = 1;
    run_valid = 0;
    for (int i = 0; i < 10000; i++) begin
      ped_req = ($urandom_range(15) == 0);
      if ($urandom_range(63) == 0) flash_en = ~flash_en;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
